minute_hand_decoder: RTL and testbench

Consumer end of the minute-clock interface. It takes the 60 s-period square wave produced by the seconds-domain minute counter, which toggles every 30 s and has one rising edge per minute. It brings that wave into the system clock domain, counts minutes and hours on a 12-hour dial, and presents registered hand positions to the analog hand drivers. A valid/ready load port sets the time.

---
 rtl/clock_pkg.sv | 25 ++
 rtl/minute_clock_sync.sv | 74 +++++++
 rtl/minute_hand_decoder.sv | 131 +++++++++++++
 tb/tb_minute_hand_decoder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared dial constants, widths, FSM state type and the hour-hand position helper
// for the minute-clock consumer.
package clock_pkg;

   localparam int MINUTES_PER_HOUR      = 60;
   localparam int HOURS_PER_DIAL        = 12;
   localparam int MINUTES_PER_HOUR_STEP = 12;
   localparam int MINUTE_W              = 6;
   localparam int HOUR_W                = 4;
   localparam int TICKS_PER_HOUR        = MINUTES_PER_HOUR / MINUTES_PER_HOUR_STEP;

   typedef enum logic [0:0] {
      RUN = 1'b0,
      ARM = 1'b1
   } state_e;

   // The hour hand creeps one tick every MINUTES_PER_HOUR_STEP minutes; worst case 11*5+4 = 59 fits in 6 bits.
   function automatic logic [MINUTE_W-1:0] hand_pos(input logic [HOUR_W-1:0]   hour,
                                                    input logic [MINUTE_W-1:0] minute);
      logic [MINUTE_W-1:0] base_s;
      base_s = MINUTE_W'(hour) * MINUTE_W'(TICKS_PER_HOUR);
      return base_s + (minute / MINUTE_W'(MINUTES_PER_HOUR_STEP));
   endfunction

endpackage

// File: rtl/minute_clock_sync.sv
// Brings the asynchronous minute square wave into the system clock domain and flags its rising edge.
// Optional glitch filter selected by MINUTE_CLOCK_FILTER_EN.
module minute_clock_sync #(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic minute_clock,
   output logic lvl,
   output logic rise
);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("minute_clock_sync: SYNC_STAGES must be in 2..4");
   end
   if (FILTER_CYCLES < 1) begin : g_bad_filter
      $error("minute_clock_sync: FILTER_CYCLES must be at least 1");
   end

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   lvl_s;
   logic                   lvl_prev_r;

   // Synchronizer chain; resets high so a wave already high at reset never looks like a rise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r <= {SYNC_STAGES{1'b1}};
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], minute_clock};
      end
   end

`ifdef MINUTE_CLOCK_FILTER_EN
   localparam int CNT_W = $clog2(FILTER_CYCLES + 1);

   logic [CNT_W-1:0] cnt_r;
   logic             lvl_r;

   // Level only flips after FILTER_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lvl_r <= 1'b1;
         cnt_r <= {CNT_W{1'b0}};
      end else if (sync_r[SYNC_STAGES-1] != lvl_r) begin
         if (cnt_r == CNT_W'(FILTER_CYCLES - 1)) begin
            lvl_r <= ~lvl_r;
            cnt_r <= {CNT_W{1'b0}};
         end else begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
      end else begin
         cnt_r <= {CNT_W{1'b0}};
      end
   end

   assign lvl_s = lvl_r;
`else
   assign lvl_s = sync_r[SYNC_STAGES-1];
`endif

   // Previous filtered level for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lvl_prev_r <= 1'b1;
      end else begin
         lvl_prev_r <= lvl_s;
      end
   end

   assign lvl  = lvl_s;
   assign rise = lvl_s & ~lvl_prev_r;

endmodule

// File: rtl/minute_hand_decoder.sv
// Minute/hour dial counter driven by the synchronized minute wave, with a valid/ready time-load port.
// Build option: MINUTE_CLOCK_FILTER_EN enables the glitch filter in minute_clock_sync.
module minute_hand_decoder
   import clock_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 4
) (
   input  logic                systemClock,
   input  logic                resetN,
   input  logic                minuteClock,
   input  logic                setValid,
   output logic                setReady,
   input  logic [MINUTE_W-1:0] setMinute,
   input  logic [HOUR_W-1:0]   setHour,
   output logic [MINUTE_W-1:0] minuteOut,
   output logic [HOUR_W-1:0]   hourOut,
   output logic [MINUTE_W-1:0] hourHandPos,
   output logic                minuteTick,
   output logic                hourTick,
   output logic                setError
);

   logic                lvl_s;
   logic                rise_s;
   logic                xfer_s;
   logic                in_range_s;
   state_e              state_r, state_nx_s;
   logic [MINUTE_W-1:0] minute_r, minute_nx_s;
   logic [HOUR_W-1:0]   hour_r, hour_nx_s;
   logic [MINUTE_W-1:0] pos_r;
   logic                minute_tick_r, minute_tick_nx_s;
   logic                hour_tick_r, hour_tick_nx_s;
   logic                set_error_r, set_error_nx_s;
   logic                set_ready_r;

   minute_clock_sync #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
   ) u_sync (
      .clk         (systemClock),
      .rst_n       (resetN),
      .minute_clock(minuteClock),
      .lvl         (lvl_s),
      .rise        (rise_s)
   );

   assign xfer_s     = setValid & set_ready_r;
   assign in_range_s = (setMinute <= MINUTE_W'(MINUTES_PER_HOUR - 1)) &&
                       (setHour   <= HOUR_W'(HOURS_PER_DIAL - 1));

   // Next state: a load beats a simultaneous rise; ARM waits for the wave to be seen low.
   always_comb begin
      state_nx_s       = state_r;
      minute_nx_s      = minute_r;
      hour_nx_s        = hour_r;
      minute_tick_nx_s = 1'b0;
      hour_tick_nx_s   = 1'b0;
      set_error_nx_s   = 1'b0;
      case (state_r)
         RUN: begin
            if (xfer_s) begin
               if (in_range_s) begin
                  minute_nx_s = setMinute;
                  hour_nx_s   = setHour;
                  state_nx_s  = ARM;
               end else begin
                  set_error_nx_s = 1'b1;
               end
            end else if (rise_s) begin
               minute_tick_nx_s = 1'b1;
               if (minute_r == MINUTE_W'(MINUTES_PER_HOUR - 1)) begin
                  minute_nx_s    = {MINUTE_W{1'b0}};
                  hour_tick_nx_s = 1'b1;
                  if (hour_r == HOUR_W'(HOURS_PER_DIAL - 1)) begin
                     hour_nx_s = {HOUR_W{1'b0}};
                  end else begin
                     hour_nx_s = hour_r + HOUR_W'(1);
                  end
               end else begin
                  minute_nx_s = minute_r + MINUTE_W'(1);
               end
            end else begin
               state_nx_s = RUN;
            end
         end
         ARM: begin
            if (!lvl_s) begin
               state_nx_s = RUN;
            end else begin
               state_nx_s = ARM;
            end
         end
         default: begin
            state_nx_s = RUN;
         end
      endcase
   end

   // State, counters and all outputs are registered together.
   always_ff @(posedge systemClock or negedge resetN) begin
      if (!resetN) begin
         state_r       <= RUN;
         minute_r      <= {MINUTE_W{1'b0}};
         hour_r        <= {HOUR_W{1'b0}};
         pos_r         <= {MINUTE_W{1'b0}};
         minute_tick_r <= 1'b0;
         hour_tick_r   <= 1'b0;
         set_error_r   <= 1'b0;
         set_ready_r   <= 1'b1;
      end else begin
         state_r       <= state_nx_s;
         minute_r      <= minute_nx_s;
         hour_r        <= hour_nx_s;
         pos_r         <= hand_pos(hour_nx_s, minute_nx_s);
         minute_tick_r <= minute_tick_nx_s;
         hour_tick_r   <= hour_tick_nx_s;
         set_error_r   <= set_error_nx_s;
         set_ready_r   <= (state_nx_s == RUN);
      end
   end

   assign setReady    = set_ready_r;
   assign minuteOut   = minute_r;
   assign hourOut     = hour_r;
   assign hourHandPos = pos_r;
   assign minuteTick  = minute_tick_r;
   assign hourTick    = hour_tick_r;
   assign setError    = set_error_r;

endmodule

// File: tb/tb_minute_hand_decoder.sv
// Self-checking bench for minute_hand_decoder: directed scenarios plus randomized loads and
// minute pulses, checked against a total-minutes dial model. Honours MINUTE_CLOCK_FILTER_EN.
module tb_minute_hand_decoder;

   localparam int SYNC_STAGES   = 2;
   localparam int FILTER_CYCLES = 4;
`ifdef MINUTE_CLOCK_FILTER_EN
   localparam int LAT = SYNC_STAGES + 1 + FILTER_CYCLES;
`else
   localparam int LAT = SYNC_STAGES + 1;
`endif

   logic       systemClock = 1'b0;
   logic       resetN      = 1'b0;
   logic       minuteClock = 1'b1;
   logic       setValid    = 1'b0;
   logic [5:0] setMinute   = 6'd0;
   logic [3:0] setHour     = 4'd0;
   logic       setReady;
   logic [5:0] minuteOut;
   logic [3:0] hourOut;
   logic [5:0] hourHandPos;
   logic       minuteTick;
   logic       hourTick;
   logic       setError;

   int check_cnt = 0;
   int error_cnt = 0;
   int tick_cnt  = 0;
   int model_min = 0;   // minutes since 12:00 on the dial, 0..719

   always #5 systemClock = ~systemClock;

   minute_hand_decoder #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
   ) dut (
      .systemClock(systemClock),
      .resetN     (resetN),
      .minuteClock(minuteClock),
      .setValid   (setValid),
      .setReady   (setReady),
      .setMinute  (setMinute),
      .setHour    (setHour),
      .minuteOut  (minuteOut),
      .hourOut    (hourOut),
      .hourHandPos(hourHandPos),
      .minuteTick (minuteTick),
      .hourTick   (hourTick),
      .setError   (setError)
   );

   always @(negedge systemClock) begin
      if (minuteTick) tick_cnt++;
   end

   task automatic check_value(input string tag, input int obs, input int exp);
      check_cnt++;
      if (obs != exp) begin
         error_cnt++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge systemClock);
         #1;
      end
   endtask

   task automatic check_time(input string tag);
      check_value({tag, "_minute"}, int'(minuteOut), model_min % 60);
      check_value({tag, "_hour"}, int'(hourOut), model_min / 60);
      check_value({tag, "_handpos"}, int'(hourHandPos), model_min / 12);
   endtask

   task automatic minute_pulse(input string tag);
      int wrap;
      int tc;
      wrap = ((model_min % 60) == 59) ? 1 : 0;
      tc   = tick_cnt;
      minuteClock = 1'b1;
      step(LAT - 1);
      check_value({tag, "_early"}, int'(minuteTick), 0);
      step();
      model_min = (model_min + 1) % 720;
      check_value({tag, "_mtick"}, int'(minuteTick), 1);
      check_value({tag, "_htick"}, int'(hourTick), wrap);
      check_time(tag);
      step();
      check_value({tag, "_mtick_end"}, int'(minuteTick), 0);
      minuteClock = 1'b0;
      step(LAT + 2);
      check_value({tag, "_tick_count"}, tick_cnt - tc, 1);
   endtask

   task automatic load(input int m, input int h, input string tag);
      int budget;
      budget    = 0;
      setMinute = 6'(m);
      setHour   = 4'(h);
      setValid  = 1'b1;
      while (!setReady && budget < 50) begin
         step();
         budget++;
      end
      check_value({tag, "_ready_wait"}, int'(budget < 50), 1);
      step();
      setValid = 1'b0;
      if (m <= 59 && h <= 11) begin
         model_min = h * 60 + m;
         check_value({tag, "_err"}, int'(setError), 0);
         check_value({tag, "_ready_low"}, int'(setReady), 0);
      end else begin
         check_value({tag, "_err"}, int'(setError), 1);
         check_value({tag, "_ready_kept"}, int'(setReady), 1);
      end
      check_value({tag, "_no_mtick"}, int'(minuteTick), 0);
      check_value({tag, "_no_htick"}, int'(hourTick), 0);
      check_time(tag);
      step();
      check_value({tag, "_err_end"}, int'(setError), 0);
      check_value({tag, "_ready_back"}, int'(setReady), 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int tc;
      int budget;
      int r;

      // Reset held with the wave high: no tick after release.
      step(3);
      check_time("rst_hold");
      check_value("rst_mtick", int'(minuteTick), 0);
      check_value("rst_err", int'(setError), 0);
      step(17);
      tc     = tick_cnt;
      resetN = 1'b1;
      step(LAT + 8);
      check_value("rst_high_no_tick", tick_cnt - tc, 0);
      check_value("rst_ready", int'(setReady), 1);
      check_time("rst_release");
      minuteClock = 1'b0;
      step(LAT + 2);

      for (int i = 0; i < 3; i++) minute_pulse("run3");
      check_value("run3_total", model_min, 3);

      load(59, 11, "load_59_11");
      minute_pulse("wrap_dial");
      load(59, 4, "load_59_4");
      minute_pulse("wrap_hour");
      load(60, 3, "load_bad_min");
      load(10, 12, "load_bad_hour");

      // Load coinciding with a rise: load wins, ARM until the wave goes low.
      tc          = tick_cnt;
      setMinute   = 6'd30;
      setHour     = 4'd5;
      minuteClock = 1'b1;
      step(LAT - 1);
      setValid = 1'b1;
      step();
      setValid  = 1'b0;
      model_min = 5 * 60 + 30;
      check_time("collide");
      check_value("collide_mtick", int'(minuteTick), 0);
      check_value("collide_ready", int'(setReady), 0);
      step(10);
      check_value("collide_ready_hold", int'(setReady), 0);
      check_value("collide_no_tick", tick_cnt - tc, 0);
      check_time("collide_hold");
      minuteClock = 1'b0;
      budget      = 0;
      while (!setReady && budget < LAT + 5) begin
         step();
         budget++;
      end
      check_value("collide_ready_return", int'(setReady), 1);
      step(2);

      for (int i = 0; i < 12; i++) begin
         r = int'($urandom_range(0, 3));
         if (r == 0) begin
            load(int'($urandom_range(0, 59)), int'($urandom_range(0, 11)), "rnd_load");
         end else if (r == 1) begin
            if ($urandom_range(0, 1) == 0)
               load(int'($urandom_range(60, 63)), int'($urandom_range(0, 15)), "rnd_bad");
            else
               load(int'($urandom_range(0, 59)), int'($urandom_range(12, 15)), "rnd_bad");
         end else begin
            repeat (int'($urandom_range(1, 3))) minute_pulse("rnd_pulse");
         end
      end

`ifdef MINUTE_CLOCK_FILTER_EN
      tc          = tick_cnt;
      minuteClock = 1'b1;
      step(2);
      minuteClock = 1'b0;
      step(LAT + 4);
      check_value("filter_glitch", tick_cnt - tc, 0);
      check_time("filter_glitch");
      tc          = tick_cnt;
      minuteClock = 1'b1;
      step(6);
      minuteClock = 1'b0;
      step(LAT + 4);
      model_min = (model_min + 1) % 720;
      check_value("filter_pulse", tick_cnt - tc, 1);
      check_time("filter_pulse");
`endif

      // Reset mid-operation with a load pending.
      load(45, 7, "pre_reset");
      setMinute = 6'd10;
      setHour   = 4'd2;
      setValid  = 1'b1;
      tc        = tick_cnt;
      resetN    = 1'b0;
      #2;
      model_min = 0;
      check_time("midrst");
      check_value("midrst_ready", int'(setReady), 1);
      step(2);
      setValid = 1'b0;
      resetN   = 1'b1;
      step(LAT + 2);
      check_time("midrst_after");
      check_value("midrst_no_tick", tick_cnt - tc, 0);
      minute_pulse("post_reset");

      $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
      $finish;
   end

endmodule
